// File: rtl/linear_to_log_pipe_pkg.sv
// Shared types and helpers for the linear-to-log2 pipeline.
// Holds the width derivations, the stage-1 record and the log2 fraction LUT generator.
package linear_to_log_pipe_pkg;

   localparam int S1_EXP_MAX  = 8;
   localparam int S1_FRAC_MAX = 16;
   localparam int LUT_IN_MIN  = 1;
   localparam int LUT_IN_MAX  = 16;
   localparam int LUT_OUT_MIN = 1;
   localparam int LUT_OUT_MAX = 20;

   typedef struct packed {
      logic                          sign;
      logic                          zero;
      logic signed [S1_EXP_MAX-1:0]  exp;
      logic        [S1_FRAC_MAX-1:0] frac;
   } s1_rec_t;

   function automatic int exp_w(input int acc_width);
      return $clog2(acc_width) + 1;
   endfunction

   function automatic int log_w(input int acc_width, input int frac_out);
      return exp_w(acc_width) + frac_out;
   endfunction

   // round(log2(1 + idx/2^fin) * 2^fout) by repeated squaring in Q30
   function automatic int log2_frac(input int idx, input int fin,
                                    input int fout);
      longint x;
      int     bits;
      x    = longint'((1 << fin) + idx) << (30 - fin);
      bits = 0;
      for (int i = 0; i <= fout; i++) begin
         x    = (x * x) >>> 30;
         bits = bits << 1;
         if (x >= (longint'(2) << 30)) begin
            bits = bits | 1;
            x    = x >>> 1;
         end
      end
      return (bits + 1) >>> 1;
   endfunction

endpackage

// File: rtl/linear_to_log_pipe_norm.sv
// Leading-one detector with left normalization.
// Returns the MSB position and the FRAC_IN bits just below it, zero-filled.
module leading_one_norm #(
   parameter  int ACC_WIDTH = 16,
   parameter  int FRAC_IN   = 8,
   localparam int PW        = $clog2(ACC_WIDTH)
) (
   input  logic [ACC_WIDTH-1:0] mag,
   output logic [PW-1:0]        pos,
   output logic [FRAC_IN-1:0]   frac,
   output logic                 zero
);

   localparam int WW = ACC_WIDTH + FRAC_IN;

   logic [WW-1:0] wide;
   logic          unused_bits;

   always_comb begin
      pos = '0;
      for (int i = 0; i < ACC_WIDTH; i++) begin
         if (mag[i]) pos = PW'(i);
      end
      zero = (mag == '0);
      wide = {mag, {FRAC_IN{1'b0}}} << (PW'(ACC_WIDTH - 1) - pos);
      frac = wide[WW-2 -: FRAC_IN];
   end

   assign unused_bits = ^{wide[WW-1], wide[WW-2-FRAC_IN:0]};

endmodule

// File: rtl/linear_to_log_pipe.sv
// Two-stage unsigned-magnitude to log2 converter with valid/ready flow.
// Stage 1 normalizes, stage 2 looks up the fraction and forms the result.
module linear_to_log_pipe
   import linear_to_log_pipe_pkg::*;
#(
   parameter  int ACC_WIDTH = 16,
   parameter  int ACC_FRAC  = 8,
   parameter  int FRAC_IN   = 8,
   parameter  int FRAC_OUT  = 7,
   localparam int EXP_W     = exp_w(ACC_WIDTH),
   localparam int LOG_W     = log_w(ACC_WIDTH, FRAC_OUT)
) (
   input  logic                 clock,
   input  logic                 resetn,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 in_sign,
   input  logic [ACC_WIDTH-1:0] in_mag,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 out_sign,
   output logic                 out_zero,
   output logic [LOG_W-1:0]     out_log
);

   localparam int PW    = $clog2(ACC_WIDTH);
   localparam int LUT_W = FRAC_OUT + 1;

   if (FRAC_IN < LUT_IN_MIN || FRAC_IN > LUT_IN_MAX ||
       FRAC_OUT < LUT_OUT_MIN || FRAC_OUT > LUT_OUT_MAX ||
       EXP_W > S1_EXP_MAX || ACC_WIDTH < 2) begin : g_bad_cfg
      $error("linear_to_log_pipe: unsupported FRAC_IN/FRAC_OUT/ACC_WIDTH");
   end

   logic [LUT_W-1:0] lut_rom [2**FRAC_IN];
   for (genvar g = 0; g < 2**FRAC_IN; g++) begin : g_lut
      assign lut_rom[g] = LUT_W'(log2_frac(g, FRAC_IN, FRAC_OUT));
   end

   logic [PW-1:0]      ln_pos;
   logic [FRAC_IN-1:0] ln_frac;
   logic               ln_zero;

   leading_one_norm #(
      .ACC_WIDTH (ACC_WIDTH),
      .FRAC_IN   (FRAC_IN)
   ) u_norm (
      .mag  (in_mag),
      .pos  (ln_pos),
      .frac (ln_frac),
      .zero (ln_zero)
   );

   logic             s1_load, s2_load;
   logic             s1_valid_q, s1_valid_d;
   logic             s2_valid_q, s2_valid_d;
   s1_rec_t          s1_q, s1_d;
   logic             out_sign_q, out_sign_d;
   logic             out_zero_q, out_zero_d;
   logic [LOG_W-1:0] out_log_q, out_log_d;
   logic [EXP_W-1:0] exp_v;
   logic [LUT_W-1:0] lut_v;
   logic             unused_s1;

   always_comb begin
      s2_load    = !s2_valid_q || out_ready;
      s1_load    = !s1_valid_q || s2_load;
      s1_valid_d = s1_load ? in_valid : s1_valid_q;
      s2_valid_d = s2_load ? s1_valid_q : s2_valid_q;

      exp_v = EXP_W'(ln_pos) - EXP_W'(ACC_FRAC);
      s1_d  = s1_q;
      if (s1_load) begin
         s1_d.sign = in_sign;
         s1_d.zero = ln_zero;
         s1_d.exp  = ln_zero ? '0 : S1_EXP_MAX'($signed(exp_v));
         s1_d.frac = ln_zero ? '0 : S1_FRAC_MAX'(ln_frac);
      end

      lut_v      = lut_rom[s1_q.frac[FRAC_IN-1:0]];
      out_sign_d = out_sign_q;
      out_zero_d = out_zero_q;
      out_log_d  = out_log_q;
      if (s2_load && s1_valid_q) begin
         out_sign_d = s1_q.sign;
         out_zero_d = s1_q.zero;
         // A LUT value of 2^FRAC_OUT carries into the exponent field
         out_log_d  = s1_q.zero ? '0 :
                      {s1_q.exp[EXP_W-1:0], {FRAC_OUT{1'b0}}}
                      + LOG_W'(lut_v);
      end
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
         out_sign_q <= 1'b0;
         out_zero_q <= 1'b0;
         out_log_q  <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s2_valid_q <= s2_valid_d;
         out_sign_q <= out_sign_d;
         out_zero_q <= out_zero_d;
         out_log_q  <= out_log_d;
      end
   end

   always_ff @(posedge clock) begin
      s1_q <= s1_d;
   end

   assign unused_s1 = ^s1_q;
   assign in_ready  = s1_load;
   assign out_valid = s2_valid_q;
   assign out_sign  = out_sign_q;
   assign out_zero  = out_zero_q;
   assign out_log   = out_log_q;

endmodule

// File: tb/tb_linear_to_log_pipe.sv
// Directed bench for linear_to_log_pipe at default parameters.
// Hand-computed log2 vectors, backpressure, and mid-flight reset.
module tb_linear_to_log_pipe;

   logic        clock = 1'b0;
   logic        resetn;
   logic        in_valid;
   logic        in_ready;
   logic        in_sign;
   logic [15:0] in_mag;
   logic        out_valid;
   logic        out_ready;
   logic        out_sign;
   logic        out_zero;
   logic [11:0] out_log;

   int n_vec  = 0;
   int n_miss = 0;

   always #5 clock = ~clock;

   linear_to_log_pipe dut (
      .clock     (clock),
      .resetn    (resetn),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_sign   (in_sign),
      .in_mag    (in_mag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sign  (out_sign),
      .out_zero  (out_zero),
      .out_log   (out_log)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_miss++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Single word through an idle pipe, checked 2 cycles after acceptance
   task automatic send(input string tag, input logic [15:0] mag,
                       input logic sgn, input logic [11:0] elog,
                       input logic ezero);
      in_valid = 1'b1;
      in_mag   = mag;
      in_sign  = sgn;
      #1;
      chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      chk({tag, "_v1"}, 32'(out_valid), 32'd0);
      tick();
      chk({tag, "_vld"}, 32'(out_valid), 32'd1);
      chk({tag, "_log"}, 32'(out_log), 32'(elog));
      chk({tag, "_zero"}, 32'(out_zero), 32'(ezero));
      chk({tag, "_sign"}, 32'(out_sign), 32'(sgn));
      tick();
   endtask

   initial begin
      resetn    = 1'b0;
      in_valid  = 1'b0;
      in_sign   = 1'b0;
      in_mag    = '0;
      out_ready = 1'b1;
      tick();
      tick();
      resetn = 1'b1;
      #1;
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_log", 32'(out_log), 32'd0);
      chk("rst_zero", 32'(out_zero), 32'd0);
      chk("rst_sign", 32'(out_sign), 32'd0);
      chk("rst_ready", 32'(in_ready), 32'd1);

      send("one", 16'h0100, 1'b0, 12'd0, 1'b0);
      send("four", 16'h0400, 1'b0, 12'd256, 1'b0);
      send("lsb", 16'h0001, 1'b1, 12'hC00, 1'b0);
      send("msb", 16'h8000, 1'b0, 12'd896, 1'b0);
      send("zero", 16'h0000, 1'b1, 12'd0, 1'b1);
      send("lut80", 16'h0180, 1'b0, 12'd75, 1'b0);
      send("lutff", 16'h01FF, 1'b0, 12'd128, 1'b0);

      // Backpressure: three back-to-back words with the sink stalled
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_sign   = 1'b0;
      in_mag    = 16'h0100;
      #1;
      chk("bp_rdy_a", 32'(in_ready), 32'd1);
      tick();
      in_mag = 16'h0400;
      chk("bp_rdy_b", 32'(in_ready), 32'd1);
      tick();
      in_mag = 16'h8000;
      chk("bp_rdy_c", 32'(in_ready), 32'd0);
      chk("bp_vld", 32'(out_valid), 32'd1);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("bp_hold_rdy", 32'(in_ready), 32'd0);
         chk("bp_hold_log", 32'(out_log), 32'd0);
         chk("bp_hold_vld", 32'(out_valid), 32'd1);
      end
      out_ready = 1'b1;
      #1;
      chk("bp_release_rdy", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      chk("bp_out_b_vld", 32'(out_valid), 32'd1);
      chk("bp_out_b", 32'(out_log), 32'd256);
      tick();
      chk("bp_out_c_vld", 32'(out_valid), 32'd1);
      chk("bp_out_c", 32'(out_log), 32'd896);
      tick();
      chk("bp_drained", 32'(out_valid), 32'd0);

      // Reset with both stages full
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_mag    = 16'h0001;
      tick();
      in_mag = 16'h0180;
      tick();
      in_valid = 1'b0;
      chk("full_vld", 32'(out_valid), 32'd1);
      chk("full_rdy", 32'(in_ready), 32'd0);
      resetn = 1'b0;
      tick();
      resetn = 1'b1;
      #1;
      chk("mid_rst_vld", 32'(out_valid), 32'd0);
      chk("mid_rst_rdy", 32'(in_ready), 32'd1);
      chk("mid_rst_log", 32'(out_log), 32'd0);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("no_stale", 32'(out_valid), 32'd0);
      end

      send("post_rst", 16'h0400, 1'b1, 12'd256, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
